ac97_link_framer: RTL and testbench
===================================

Name: ac97_link_framer

Overview:
- Bit-level AC'97 link engine in the AC97_BIT_CLK domain (12.288 MHz), sitting directly below the audio top block and driving the codec pins.
- Builds 256-bit output frames (SYNC, tag slot, command slots 1/2, PCM slots 3/4) from a sample handshake and a command handshake.
- Deserializes codec input frames into register status and PCM capture pulses.
- Contains no clock-domain crossing. Upstream FIFOs live in the same clock domain.

Parameters:
- SAMPLE_W, 16, PCM sample width; left-justified in each 20-bit slot, low bits zero (1..20).
- SYNC_LEN, 16, number of bit clocks SYNC is held high at frame start.

Ports:
- AC97_BIT_CLK  in  1  codec bit clock; sole clock, rising edge only
- SYS_RST_N  in  1  asynchronous active-low reset
- ac97_sdata_in  in  1  serial data from codec
- ac97_sdata_out  out  1  serial data to codec
- ac97_synch  out  1  frame sync to codec
- frame_start  out  1  one-cycle pulse at bit 255 (frame load point)
- out_valid  in  1  playback sample pair available
- out_ready  out  1  high only in bit-255 cycle
- out_left  in  SAMPLE_W  playback left (slot 3)
- out_right  in  SAMPLE_W  playback right (slot 4)
- cmd_valid  in  1  register command pending
- cmd_ready  out  1  high only in bit-255 cycle
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  7  codec register index
- cmd_data  in  16  write data
- sts_valid  out  1  one-cycle pulse: status slot received
- sts_addr  out  7  returned register index
- sts_data  out  16  returned register data
- in_valid  out  1  one-cycle pulse: capture pair received
- in_left  out  SAMPLE_W  capture left (slot 3 bits 19 down)
- in_right  out  SAMPLE_W  capture right (slot 4)
- codec_ready  out  1  tag bit 15 of last received frame
- underrun_cnt  out  8  frames sent without sample; saturating

Behaviour:
- Bit counter b:
  - 8 bits, 0..255, wraps 255->0.
  - Free-running from reset release; reset value 0.
- Slot map:
  - Slot 0 occupies b=0..15 (tag bit 15 first).
  - Slot n (1..12) occupies b=16+20(n-1) .. +19, MSB first.
- Output timing:
  - ac97_synch is registered; high during cycles b=0..SYNC_LEN-1, else low.
  - ac97_sdata_out is registered; carries frame bit b during cycle b.
- Load point (cycle b==255):
  - out_ready=1 and cmd_ready=1; both are 0 in every other cycle.
  - Transfer occurs iff the ready/valid pair is high in that cycle.
  - Transferred values go to shadow registers used for the entire next frame.
  - With no sample transfer: slots 3/4 are zero, tag bits 12/11 are 0, underrun_cnt increments (holds at 255).
  - With no command transfer: slots 1/2 are zero, tag bits 14/13 are 0.
- Tag slot:
  - bit15 = OR of bits 14..11.
  - bit14 = command present; bit13 = command present AND write; bit12 = bit11 = sample present.
  - bits 10..0 are 0.
- Command slots:
  - Slot 1: bit19 = rw, bits18:12 = addr, rest 0.
  - Slot 2: bits19:4 = data, rest 0; zero for reads.
- Input deserializer:
  - ac97_sdata_in is registered on the rising edge; input bit b is captured in cycle b+1 (mod 256).
  - Evaluation happens in cycle b==0, after bit 255 of the prior frame is captured:
    - codec_ready <= rx tag bit 15.
    - If rx tag bits 14 and 13 are both 1: sts_valid pulses; sts_addr = rx slot1[18:12]; sts_data = rx slot2[19:4].
    - If rx tag bits 12 and 11 are both 1: in_valid pulses; in_left/in_right take rx slot3/slot4 [19:20-SAMPLE_W].
  - Data outputs hold their values until the next update.
- Simultaneous events: command and sample in the same load cycle are both accepted and both sent in the same frame.
- Reset:
  - All outputs 0, counter 0, shadows cleared, immediately on SYS_RST_N low, including mid-frame.
  - After release, the first frame (b=0..255) carries a zero tag.
  - The first load point is at b=255 of that frame; its underrun is counted if out_valid=0.
- Latency:
  - out_valid accepted at b=255 -> slot 3 MSB appears on ac97_sdata_out 57 cycles later (b=56).
  - Tag bit 15 appears 1 cycle later.

Test Plan:
- Reset release, no valids, 3 frames:
  - ac97_synch high exactly b=0..15 each frame; ac97_sdata_out constant 0.
  - underrun_cnt=3; out_ready pulses once per 256 cycles.
- out_valid=1, out_left=16'hA5C3, out_right=16'h0001 held:
  - tag=16'h9800; slot3 bits = A5C3 followed by 4'b0000; slot4 = 0001_0000.
  - underrun_cnt stops incrementing.
- Command write, cmd_addr=7'h02, cmd_data=16'h8000, rw=0, at load point:
  - tag=16'hE000; slot1=20'h02000; slot2=20'h80000.
  - Next frame: tag=0 if no new command.
- Codec model returns tag 16'hE000, slot1=20'h26000, slot2=20'h000F0:
  - sts_valid pulses once at following b==0.
  - sts_addr=7'h26, sts_data=16'h000F, codec_ready=1.
- Codec model returns tag 16'h9800, slot3=20'h7FFF0, slot4=20'h80000:
  - in_valid pulses one cycle with in_left=16'h7FFF, in_right=16'h8000.
- Assert SYS_RST_N low at b=100 mid-frame with command pending:
  - All outputs 0 immediately; after release counter restarts at 0.
  - Command not resent unless re-presented.
  - underrun_cnt held at 255 after 300 empty frames.

Source files
------------

// File: rtl/ac97_link_framer.sv
// AC'97 bit-level link engine: serializes 256-bit output frames from the sample/command
// handshakes and deserializes codec input frames into status and capture pulses.
module ac97_link_framer #(
  parameter int SAMPLE_W = 16,
  parameter int SYNC_LEN = 16
) (
  input  logic                AC97_BIT_CLK,
  input  logic                SYS_RST_N,
  input  logic                ac97_sdata_in,
  output logic                ac97_sdata_out,
  output logic                ac97_synch,
  output logic                frame_start,
  input  logic                out_valid,
  output logic                out_ready,
  input  logic [SAMPLE_W-1:0] out_left,
  input  logic [SAMPLE_W-1:0] out_right,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rw,
  input  logic [6:0]          cmd_addr,
  input  logic [15:0]         cmd_data,
  output logic                sts_valid,
  output logic [6:0]          sts_addr,
  output logic [15:0]         sts_data,
  output logic                in_valid,
  output logic [SAMPLE_W-1:0] in_left,
  output logic [SAMPLE_W-1:0] in_right,
  output logic                codec_ready,
  output logic [7:0]          underrun_cnt
);

  localparam logic [8:0] LP_SYNC = 9'(SYNC_LEN);
  localparam logic [7:0] LP_L_HI = 8'(56 + SAMPLE_W - 1);
  localparam logic [7:0] LP_R_HI = 8'(76 + SAMPLE_W - 1);

  logic [7:0]          r_bit_cnt;
  logic                r_cmd_vld, r_cmd_rw, r_smp_vld;
  logic [6:0]          r_cmd_addr;
  logic [15:0]         r_cmd_data;
  logic [SAMPLE_W-1:0] r_left, r_right;
  logic                r_sdo, r_sync;
  logic [7:0]          r_underrun;

  logic [4:0]          r_rx_tag;
  logic [6:0]          r_rx_addr;
  logic [15:0]         r_rx_data;
  logic [SAMPLE_W-1:0] r_rx_left, r_rx_right;
  logic                r_sts_valid, r_in_valid, r_codec_ready;
  logic [6:0]          r_sts_addr;
  logic [15:0]         r_sts_data;
  logic [SAMPLE_W-1:0] r_in_left, r_in_right;

  logic                w_load;
  logic [7:0]          w_bit_next;
  logic                w_cmd_vld, w_cmd_rw, w_smp_vld;
  logic [6:0]          w_cmd_addr;
  logic [15:0]         w_cmd_data;
  logic [SAMPLE_W-1:0] w_left, w_right;
  logic [3:0]          w_tag_flags;
  logic [15:0]         w_tag;
  logic [19:0]         w_slot1, w_slot2, w_slot3, w_slot4;
  logic [255:0]        w_frame;

  assign w_load     = (r_bit_cnt == 8'hFF);
  assign w_bit_next = r_bit_cnt + 8'd1;

  // Shadow contents seen by the next frame; the load-point values are used directly so the
  // tag MSB can leave on the very next cycle.
  always_comb begin
    w_cmd_vld  = r_cmd_vld;
    w_cmd_rw   = r_cmd_rw;
    w_cmd_addr = r_cmd_addr;
    w_cmd_data = r_cmd_data;
    w_smp_vld  = r_smp_vld;
    w_left     = r_left;
    w_right    = r_right;
    if (w_load) begin
      w_cmd_vld  = cmd_valid;
      w_cmd_rw   = cmd_valid & cmd_rw;
      w_cmd_addr = cmd_valid ? cmd_addr : '0;
      w_cmd_data = (cmd_valid & ~cmd_rw) ? cmd_data : '0;
      w_smp_vld  = out_valid;
      w_left     = out_valid ? out_left : '0;
      w_right    = out_valid ? out_right : '0;
    end
  end

  assign w_tag_flags = {w_cmd_vld, w_cmd_vld & ~w_cmd_rw, w_smp_vld, w_smp_vld};
  assign w_tag       = {|w_tag_flags, w_tag_flags, 11'd0};
  assign w_slot1     = {w_cmd_rw, w_cmd_addr, 12'd0};
  assign w_slot2     = {w_cmd_data, 4'd0};
  assign w_slot3     = 20'(w_left) << (20 - SAMPLE_W);
  assign w_slot4     = 20'(w_right) << (20 - SAMPLE_W);
  // Frame bit b lives at index 255-b, so slot 0 MSB is the vector MSB.
  assign w_frame     = {w_tag, w_slot1, w_slot2, w_slot3, w_slot4, 160'd0};

  always_ff @(posedge AC97_BIT_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_bit_cnt  <= '0;
      r_cmd_vld  <= 1'b0;
      r_cmd_rw   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_data <= '0;
      r_smp_vld  <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_sdo      <= 1'b0;
      r_sync     <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_bit_cnt  <= w_bit_next;
      r_cmd_vld  <= w_cmd_vld;
      r_cmd_rw   <= w_cmd_rw;
      r_cmd_addr <= w_cmd_addr;
      r_cmd_data <= w_cmd_data;
      r_smp_vld  <= w_smp_vld;
      r_left     <= w_left;
      r_right    <= w_right;
      r_sdo      <= w_frame[~w_bit_next];
      r_sync     <= ({1'b0, w_bit_next} < LP_SYNC);
      if (w_load && !out_valid && (r_underrun != 8'hFF))
        r_underrun <= r_underrun + 8'd1;
    end
  end

  // Only the received bits that feed an output are kept; each field shifts in MSB first.
  always_ff @(posedge AC97_BIT_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_rx_tag      <= '0;
      r_rx_addr     <= '0;
      r_rx_data     <= '0;
      r_rx_left     <= '0;
      r_rx_right    <= '0;
      r_sts_valid   <= 1'b0;
      r_in_valid    <= 1'b0;
      r_codec_ready <= 1'b0;
      r_sts_addr    <= '0;
      r_sts_data    <= '0;
      r_in_left     <= '0;
      r_in_right    <= '0;
    end else begin
      if (r_bit_cnt <= 8'd4)
        r_rx_tag <= {r_rx_tag[3:0], ac97_sdata_in};
      if (r_bit_cnt >= 8'd17 && r_bit_cnt <= 8'd23)
        r_rx_addr <= {r_rx_addr[5:0], ac97_sdata_in};
      if (r_bit_cnt >= 8'd36 && r_bit_cnt <= 8'd51)
        r_rx_data <= {r_rx_data[14:0], ac97_sdata_in};
      if (r_bit_cnt >= 8'd56 && r_bit_cnt <= LP_L_HI)
        r_rx_left <= SAMPLE_W'({r_rx_left, ac97_sdata_in});
      if (r_bit_cnt >= 8'd76 && r_bit_cnt <= LP_R_HI)
        r_rx_right <= SAMPLE_W'({r_rx_right, ac97_sdata_in});
      r_sts_valid <= 1'b0;
      r_in_valid  <= 1'b0;
      if (w_load) begin
        r_codec_ready <= r_rx_tag[4];
        if (r_rx_tag[3] && r_rx_tag[2]) begin
          r_sts_valid <= 1'b1;
          r_sts_addr  <= r_rx_addr;
          r_sts_data  <= r_rx_data;
        end
        if (r_rx_tag[1] && r_rx_tag[0]) begin
          r_in_valid <= 1'b1;
          r_in_left  <= r_rx_left;
          r_in_right <= r_rx_right;
        end
      end
    end
  end

  assign ac97_sdata_out = r_sdo;
  assign ac97_synch     = r_sync;
  assign frame_start    = w_load;
  assign out_ready      = w_load;
  assign cmd_ready      = w_load;
  assign underrun_cnt   = r_underrun;
  assign sts_valid      = r_sts_valid;
  assign sts_addr       = r_sts_addr;
  assign sts_data       = r_sts_data;
  assign in_valid       = r_in_valid;
  assign in_left        = r_in_left;
  assign in_right       = r_in_right;
  assign codec_ready    = r_codec_ready;

endmodule

// File: tb/tb_ac97_link_framer.sv
// Scoreboard bench for ac97_link_framer: frame-level reference model for the serial output
// and a codec model feeding the deserializer, checked by an independent monitor.
module tb_ac97_link_framer;
  localparam int SAMPLE_W = 16;
  localparam int SYNC_LEN = 16;

  logic clk = 1'b0, rst_n = 1'b0, sdin = 1'b0;
  logic sdo, synch, frame_start, out_ready, cmd_ready;
  logic out_valid = 1'b0, cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [SAMPLE_W-1:0] out_left = '0, out_right = '0, in_left, in_right;
  logic [6:0] cmd_addr = '0, sts_addr;
  logic [15:0] cmd_data = '0, sts_data;
  logic sts_valid, in_valid, codec_ready;
  logic [7:0] underrun_cnt;

  ac97_link_framer #(.SAMPLE_W(SAMPLE_W), .SYNC_LEN(SYNC_LEN)) dut (
    .AC97_BIT_CLK(clk), .SYS_RST_N(rst_n), .ac97_sdata_in(sdin),
    .ac97_sdata_out(sdo), .ac97_synch(synch), .frame_start(frame_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_left(out_left), .out_right(out_right),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .sts_valid(sts_valid), .sts_addr(sts_addr), .sts_data(sts_data),
    .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
    .codec_ready(codec_ready), .underrun_cnt(underrun_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit rdy; bit sts; logic [6:0] addr; logic [15:0] data;
    bit cap; logic [SAMPLE_W-1:0] l; logic [SAMPLE_W-1:0] r;
  } rx_exp_t;
  typedef struct { logic [15:0] tag; logic [19:0] s1, s2, s3, s4; } rx_frm_t;

  int n_checks = 0, n_fail = 0;
  logic [255:0] tx_q[$];
  rx_exp_t rx_q[$];
  rx_frm_t dir_q[$];
  int exp_under = 0;
  bit noise_en = 0, first_cyc = 0;
  int bad_sync = 0, bad_rdy = 0, bad_pulse = 0;
  logic [255:0] tx_bits;
  logic [6:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [SAMPLE_W-1:0] last_l = '0, last_r = '0;

  // Reference bit position within the frame, restarting with the link after reset.
  logic [7:0] tb_b;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_b <= 8'd0; else tb_b <= tb_b + 8'd1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame bit b is held at index b of the returned vector.
  function automatic logic [255:0] build_frame(input logic [15:0] tag, input logic [19:0] s1,
      input logic [19:0] s2, input logic [19:0] s3, input logic [19:0] s4, input logic [159:0] rest);
    logic [255:0] f;
    logic [19:0] s [4];
    s[0] = s1; s[1] = s2; s[2] = s3; s[3] = s4;
    for (int b = 0; b < 256; b++) begin
      if (b < 16) f[b] = tag[15-b];
      else if (b < 96) f[b] = s[(b-16)/20][19-((b-16)%20)];
      else f[b] = rest[b-96];
    end
    return f;
  endfunction

  function automatic logic [255:0] tx_frame(input bit cv, input bit rw, input logic [6:0] a,
      input logic [15:0] d, input bit sv, input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    logic [15:0] tag = 16'h0;
    logic [19:0] s1, s2, s3, s4;
    if (cv) tag = tag | 16'h4000;
    if (cv && !rw) tag = tag | 16'h2000;
    if (sv) tag = tag | 16'h1800;
    if (tag != 16'h0) tag = tag | 16'h8000;
    s1 = cv ? ((20'(rw) << 19) | (20'(a) << 12)) : 20'h0;
    s2 = (cv && !rw) ? (20'(d) << 4) : 20'h0;
    s3 = sv ? (20'(l) << (20 - SAMPLE_W)) : 20'h0;
    s4 = sv ? (20'(r) << (20 - SAMPLE_W)) : 20'h0;
    return build_frame(tag, s1, s2, s3, s4, 160'h0);
  endfunction

  task automatic assert_reset();
    rst_n = 1'b0;
    tx_q.delete(); rx_q.delete(); dir_q.delete();
    exp_under = 0; bad_sync = 0; bad_rdy = 0; bad_pulse = 0;
    last_addr = '0; last_data = '0; last_l = '0; last_r = '0;
  endtask

  task automatic release_reset();
    rx_exp_t z;
    z = '{rdy: 0, sts: 0, addr: '0, data: '0, cap: 0, l: '0, r: '0};
    tx_q.push_back(256'h0);
    rx_q.push_back(z);
    first_cyc = 1;
    rst_n = 1'b1;
  endtask

  // Waits for the load cycle, drives one handshake and records the frame it must produce.
  task automatic load_frame(input bit sv, input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
      input bit cv, input bit rw, input logic [6:0] a, input logic [15:0] d);
    int guard = 0;
    do begin
      @(posedge clk); #1; guard++;
      if (tb_b != 8'd255 && noise_en) begin
        out_valid = 1'($urandom_range(0, 1)); cmd_valid = 1'($urandom_range(0, 1));
        out_left = SAMPLE_W'($urandom); cmd_addr = 7'($urandom); cmd_data = 16'($urandom);
      end
    end while (tb_b != 8'd255 && guard < 300);
    if (tb_b != 8'd255) begin
      n_checks++; n_fail++;
      $display("FAIL load_wait: got b=%0d expected b=255", tb_b);
      return;
    end
    out_valid = sv; out_left = l; out_right = r;
    cmd_valid = cv; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    tx_q.push_back(tx_frame(cv, rw, a, d, sv, l, r));
    if (!sv && exp_under < 255) exp_under++;
  endtask

  // Codec model: one frame per 256 bit clocks, bit b presented during cycle b.
  rx_frm_t cf;
  rx_exp_t ce;
  logic [255:0] rx_bits = '0;
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (tb_b == 8'd0) begin
        if (dir_q.size() > 0) cf = dir_q.pop_front();
        else begin
          cf.tag = 16'($urandom); cf.s1 = 20'($urandom); cf.s2 = 20'($urandom);
          cf.s3 = 20'($urandom); cf.s4 = 20'($urandom);
        end
        rx_bits = build_frame(cf.tag, cf.s1, cf.s2, cf.s3, cf.s4,
                              {$urandom, $urandom, $urandom, $urandom, $urandom});
        ce.rdy  = cf.tag[15];
        ce.sts  = cf.tag[14] && cf.tag[13];
        ce.addr = 7'((cf.s1 >> 12) & 20'h7F);
        ce.data = 16'(cf.s2 >> 4);
        ce.cap  = cf.tag[12] && cf.tag[11];
        ce.l    = SAMPLE_W'(cf.s3 >> (20 - SAMPLE_W));
        ce.r    = SAMPLE_W'(cf.s4 >> (20 - SAMPLE_W));
        rx_q.push_back(ce);
      end
      sdin = rx_bits[tb_b];
    end
  end

  // Monitor: gathers the serial frame, checks pulse timing and pops both scoreboards.
  rx_exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      tx_bits[tb_b] = sdo;
      if (synch !== ((tb_b < 8'(SYNC_LEN)) && !first_cyc)) bad_sync++;
      first_cyc = 0;
      if ({out_ready, cmd_ready, frame_start} !== {3{tb_b == 8'd255}}) bad_rdy++;
      if (tb_b != 8'd0 && (sts_valid || in_valid)) bad_pulse++;
      if (tb_b == 8'd255) begin
        if (tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_frame: got a frame, expected none queued");
        end else check("tx_frame", tx_bits, tx_q.pop_front());
        check("sync_bad_cycles", bad_sync, 0);
        check("ready_bad_cycles", bad_rdy, 0);
        check("stray_pulses", bad_pulse, 0);
        bad_sync = 0; bad_rdy = 0; bad_pulse = 0;
      end
      if (tb_b == 8'd0) begin
        if (rx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_eval: got evaluation point, expected none queued");
        end else begin
          me = rx_q.pop_front();
          if (me.sts) begin last_addr = me.addr; last_data = me.data; end
          if (me.cap) begin last_l = me.l; last_r = me.r; end
          check("codec_ready", codec_ready, me.rdy);
          check("sts_valid", sts_valid, me.sts);
          check("in_valid", in_valid, me.cap);
          check("sts_addr", sts_addr, last_addr);
          check("sts_data", sts_data, last_data);
          check("in_left", in_left, last_l);
          check("in_right", in_right, last_r);
        end
        check("underrun_cnt", underrun_cnt, exp_under);
      end
    end
  end

  initial begin
    int guard;
    @(posedge clk); #1;
    assert_reset();
    repeat (3) @(posedge clk);
    #1 release_reset();

    repeat (3) load_frame(0, '0, '0, 0, 0, '0, '0);
    repeat (2) load_frame(1, 16'hA5C3, 16'h0001, 0, 0, '0, '0);
    load_frame(0, '0, '0, 1, 0, 7'h02, 16'h8000);
    load_frame(0, '0, '0, 0, 0, '0, '0);
    dir_q.push_back('{tag: 16'hE000, s1: 20'h26000, s2: 20'h000F0, s3: 20'h0, s4: 20'h0});
    dir_q.push_back('{tag: 16'h9800, s1: 20'h0, s2: 20'h0, s3: 20'h7FFF0, s4: 20'h80000});
    repeat (3) load_frame(0, '0, '0, 0, 0, '0, '0);

    noise_en = 1;
    repeat (8) load_frame(1'($urandom_range(0, 1)), SAMPLE_W'($urandom), SAMPLE_W'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          7'($urandom), 16'($urandom));
    noise_en = 0;
    load_frame(0, '0, '0, 0, 0, '0, '0);

    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (tb_b != 8'd100 && guard < 300);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h55; cmd_data = 16'h1234;
    assert_reset();
    #1 check("reset_outputs_zero",
             {sdo, synch, frame_start, out_ready, cmd_ready, sts_valid, sts_addr, sts_data,
              in_valid, in_left, in_right, codec_ready, underrun_cnt}, 256'h0);
    repeat (4) @(posedge clk);
    #1 cmd_valid = 1'b0;
    release_reset();

    repeat (300) load_frame(0, '0, '0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
